burst_len_capture: RTL

Downstream consumer of the run/last strobe FSM. Counts consecutive run strobes `s`, and on each end-of-burst pulse `g` pushes a length record {saturated flag, count} into a small FIFO. The FIFO drains through a valid/ready interface to the next stage (a register bank or DMA descriptor writer). The block also flags protocol and overflow errors as sticky bits.

---
 rtl/burst_len_pkg.sv | 10 +
 rtl/burst_len_fifo.sv | 38 +++
 rtl/burst_len_capture.sv | 84 ++++++++
 3 files changed

// File: rtl/burst_len_pkg.sv
// burst_len_pkg: shared state enum, default widths and length-record type
package burst_len_pkg;
  localparam int CW_DEF = 8;
  localparam int DEPTH_DEF = 4;
  typedef enum logic {IDLE, COUNT} state_e;
  typedef struct packed {
    logic              sat;
    logic [CW_DEF-1:0] count;
  } rec_t;
endpackage

// File: rtl/burst_len_fifo.sv
// burst_len_fifo: sync FIFO (clk, rst_n, clr, push/din, pop/dout, full, empty, level); unreset storage
module burst_len_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  always_comb begin
    wp_d = clr ? '0 : wp_q + (AW+1)'(push);
    rp_d = clr ? '0 : rp_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk)
    if (push && !clr) mem_q[wp_q[AW-1:0]] <= din;
  assign dout  = mem_q[rp_q[AW-1:0]];
  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign level = wp_q - rp_q;
endmodule

// File: rtl/burst_len_capture.sv
// burst_len_capture: counts s strobes, pushes {sat,count} on g into a valid/ready FIFO; sticky ovf/proto_err
module burst_len_capture
  import burst_len_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s,
  input  logic                   g,
  input  logic                   clr,
  output logic                   len_valid,
  input  logic                   len_ready,
  output logic [CW:0]            len_data,
  output logic [$clog2(DEPTH):0] len_level,
  output logic                   ovf,
  output logic                   proto_err
);
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        sat_q, sat_d, ovf_q, ovf_d, perr_q, perr_d;
  logic        push_req, pop, wr, full, empty;
  logic [CW:0] rec, dout;
  assign pop = len_ready && !empty;
  assign wr  = push_req && (!full || pop);
  assign rec = state_q == COUNT ? {sat_q, cnt_q} : '0;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    ovf_d    = ovf_q;
    perr_d   = perr_q;
    push_req = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
      ovf_d   = 1'b0;
      perr_d  = 1'b0;
    end else if (g) begin
      push_req = 1'b1;
      state_d  = IDLE;
      cnt_d    = '0;
      sat_d    = 1'b0;
      perr_d   = perr_q || s;
      ovf_d    = ovf_q || (full && !pop);
    end else if (s) begin
      state_d = COUNT;
      sat_d   = sat_q || (cnt_q == '1);
      cnt_d   = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  burst_len_fifo #(.W(CW+1), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .push (wr),
    .pop  (pop),
    .din  (rec),
    .dout (dout),
    .full (full),
    .empty(empty),
    .level(len_level)
  );
  assign len_valid = !empty;
  assign len_data  = empty ? '0 : dout;
  assign ovf       = ovf_q;
  assign proto_err = perr_q;
endmodule
